// File: rtl/ft_arb_pkg.sv
// Shared types and constants for the FT245 TX arbiter: packet FSM states, default magic byte, channel limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft_arb_pkg;

  // Packet framing sequence; CSUM is only visited when FT_TX_ARB_CSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ID   = 3'd2,
    LEN  = 3'd3,
    PAY  = 3'd4,
    CSUM = 3'd5
  } arb_state_t;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int         MAX_CH    = 16;
  // Channel id travels in the low nibble of the ID byte, so 4 bits covers MAX_CH.
  localparam int         ID_W      = 4;

  // Round-robin pointer advance: the channel after the winner, wrapping at n_ch.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int n_ch);
    return (int'(idx) == n_ch - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ft_rr_picker.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping to channel 0.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when to register the winner.
// Ports: req (request vector), ptr (search start), win_oh (one-hot winner), win_idx (winner index), any (some req set).
module ft_rr_picker
  import ft_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [N_CH-1:0] win_oh,
  output logic [ID_W-1:0] win_idx,
  output logic            any
);

  // Two passes instead of a modulo index: channels at/after ptr first, then the wrapped ones.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        any       = 1'b1;
        win_idx   = ID_W'(j);
        win_oh[j] = 1'b1;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!any && req[j] && (j < int'(ptr))) begin
        any       = 1'b1;
        win_idx   = ID_W'(j);
        win_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin packet arbiter sharing the FT245 TX FIFO write port; frames MAGIC, id, len, payload (+csum).
// Latency: req to first MAGIC strobe 2 cycles; header and payload stream back-to-back; 1 idle cycle between packets.
// Backpressure: output register reloads only when !txfifo_wr || !txfifo_full; src_ready follows that reload enable.
// Ports: sys_clk/sys_rst (async active-high); req/req_len/src_data/src_valid/src_ready per channel;
//        grant (one-hot packet owner), txfifo_full/txfifo_wr/txfifo_data (FIFO write port), busy.
// Option: define FT_TX_ARB_CSUM_EN to append an XOR checksum byte (id ^ len ^ payload) to every packet.
module ft_tx_arbiter
  import ft_arb_pkg::*;
#(
  parameter int         N_CH   = 4,
  parameter int         DATA_W = 8,
  parameter int         LEN_W  = 8,
  parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*LEN_W-1:0]    req_len,
  input  logic [N_CH*DATA_W-1:0]   src_data,
  input  logic [N_CH-1:0]          src_valid,
  output logic [N_CH-1:0]          src_ready,
  output logic [N_CH-1:0]          grant,
  input  logic                     txfifo_full,
  output logic                     txfifo_wr,
  output logic [DATA_W-1:0]        txfifo_data,
  output logic                     busy
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic [LEN_W-1:0] cnt;
`ifdef FT_TX_ARB_CSUM_EN
  logic [7:0]      csum;
`endif

  logic            load_en;
  logic [N_CH-1:0] pick_oh;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic [LEN_W-1:0] pick_len;
  logic [DATA_W-1:0] pay_byte;
  logic            pay_valid;

  // A pending byte is either absent or being accepted this cycle.
  assign load_en = !txfifo_wr || !txfifo_full;

  ft_rr_picker #(.N_CH(N_CH)) u_picker (
    .req     (req),
    .ptr     (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Length of the candidate winner, latched at grant time only.
  always_comb begin
    pick_len = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (pick_oh[j]) pick_len = req_len[j*LEN_W +: LEN_W];
    end
  end

  // Payload mux driven by the registered one-hot grant.
  always_comb begin
    pay_byte = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (grant[j]) pay_byte = src_data[j*DATA_W +: DATA_W];
    end
  end

  assign pay_valid = |(src_valid & grant);
  assign src_ready = ((state == PAY) && load_en) ? grant : '0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      grant       <= '0;
      win_idx     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      txfifo_wr   <= 1'b0;
      txfifo_data <= '0;
      busy        <= 1'b0;
`ifdef FT_TX_ARB_CSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The last byte of the previous packet may still be stalled; only drop wr once it is taken.
          if (load_en) txfifo_wr <= 1'b0;
          if (pick_any) begin
            grant   <= pick_oh;
            win_idx <= pick_idx;
            cnt     <= pick_len;
            busy    <= 1'b1;
`ifdef FT_TX_ARB_CSUM_EN
            csum    <= 8'(pick_idx) ^ 8'(pick_len);
`endif
            state   <= HDR;
          end
        end
        HDR: begin
          if (load_en) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= MAGIC;
            state       <= ID;
          end
        end
        ID: begin
          if (load_en) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= DATA_W'(win_idx);
            state       <= LEN;
          end
        end
        LEN: begin
          if (load_en) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= 8'(cnt);
            if (cnt == '0) begin
`ifdef FT_TX_ARB_CSUM_EN
              state  <= CSUM;
`else
              state  <= IDLE;
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= next_ptr(win_idx, N_CH);
`endif
            end else begin
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (load_en) begin
            if (pay_valid) begin
              txfifo_wr   <= 1'b1;
              txfifo_data <= pay_byte;
              cnt         <= cnt - LEN_W'(1);
`ifdef FT_TX_ARB_CSUM_EN
              csum        <= csum ^ 8'(pay_byte);
`endif
              if (cnt == LEN_W'(1)) begin
`ifdef FT_TX_ARB_CSUM_EN
                state  <= CSUM;
`else
                state  <= IDLE;
                grant  <= '0;
                busy   <= 1'b0;
                rr_ptr <= next_ptr(win_idx, N_CH);
`endif
              end
            end else begin
              // Source starved: emit a bubble rather than repeat the previous byte.
              txfifo_wr <= 1'b0;
            end
          end
        end
`ifdef FT_TX_ARB_CSUM_EN
        CSUM: begin
          if (load_en) begin
            txfifo_wr   <= 1'b1;
            txfifo_data <= csum;
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            rr_ptr      <= next_ptr(win_idx, N_CH);
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Only the low 8 bits of the length reach the wire.
  generate
    if (LEN_W > 8) begin : g_len_chk
      a_len_fits : assert property (@(posedge sys_clk) disable iff (sys_rst)
        ((state == IDLE) && pick_any) |-> (pick_len < LEN_W'(256)));
    end
  endgenerate

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter: per-scenario tasks drive channels and compare the captured FIFO stream.
module tb_ft_tx_arbiter;

  localparam int N_CH = 4;

  logic              sys_clk;
  logic              sys_rst;
  logic [N_CH-1:0]   req;
  logic [N_CH*8-1:0] req_len;
  logic [N_CH*8-1:0] src_data;
  logic [N_CH-1:0]   src_valid;
  logic [N_CH-1:0]   src_ready;
  logic [N_CH-1:0]   grant;
  logic              txfifo_full;
  logic              txfifo_wr;
  logic [7:0]        txfifo_data;
  logic              busy;

  ft_tx_arbiter #(.N_CH(N_CH), .DATA_W(8), .LEN_W(8), .MAGIC(8'hA5)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .req_len     (req_len),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .grant       (grant),
    .txfifo_full (txfifo_full),
    .txfifo_wr   (txfifo_wr),
    .txfifo_data (txfifo_data),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0] src_mem [N_CH][8];
  int         src_len [N_CH];
  int         src_ptr [N_CH];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   full_mode = 1'b0;
  bit   gap_mode = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int   hold_viol, ready_viol, onehot_viol, ready_seen, bubble_cnt, stall_cnt;

  task automatic update_src();
    for (int c = 0; c < N_CH; c++) begin
      src_data[c*8 +: 8] = (src_ptr[c] < 8) ? src_mem[c][src_ptr[c]] : 8'h00;
      src_valid[c]       = (src_ptr[c] < src_len[c]) && (!gap_mode || (cyc % 3) != 0);
    end
  endtask

  task automatic clear_run();
    out_q.delete();
    exp_q.delete();
    hold_viol = 0; ready_viol = 0; onehot_viol = 0;
    ready_seen = 0; bubble_cnt = 0; stall_cnt = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      src_ptr[c] = 0;
      src_len[c] = 0;
    end
    update_src();
  endtask

  // One clock: observe at negedge, apply next inputs 1ns after posedge.
  task automatic step();
    logic [N_CH-1:0] take;
    logic [N_CH-1:0] gseen;
    @(negedge sys_clk);
    if (txfifo_wr && !txfifo_full) out_q.push_back(txfifo_data);
    if (prev_stall && (txfifo_wr !== 1'b1 || txfifo_data !== prev_data)) hold_viol++;
    prev_stall = txfifo_wr && txfifo_full;
    prev_data  = txfifo_data;
    if (txfifo_wr && txfifo_full) stall_cnt++;
    if ((src_ready & ~grant) != '0) ready_viol++;
    if ($countones(grant) > 1) onehot_viol++;
    if (src_ready != '0) ready_seen++;
    if (busy && !txfifo_wr) bubble_cnt++;
    take  = src_valid & src_ready;
    gseen = grant;
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int c = 0; c < N_CH; c++) if (take[c]) src_ptr[c]++;
    req = req & ~gseen;
    txfifo_full = full_mode ? ((cyc % 2) == 1) : 1'b0;
    update_src();
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    step();
    while (!(req == '0 && !busy && !txfifo_wr) && n < max_cyc) begin
      step();
      n++;
    end
    total++;
    if (n >= max_cyc) begin
      bad++;
      $display("FAIL %s_timeout busy=%0b wr=%0b req=%b", name, busy, txfifo_wr, req);
    end
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    req = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req = 4'b1111;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    repeat (3) @(posedge sys_clk);
    #1;
    total++; if (txfifo_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", txfifo_wr); end
    total++; if (txfifo_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", txfifo_data); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req = '0;
    sys_rst = 1'b0;
  endtask

  task automatic test_single();
    clear_run();
    src_mem[0][0] = 8'h11; src_mem[0][1] = 8'h22; src_mem[0][2] = 8'h33;
    src_len[0] = 3;
    req_len[7:0] = 8'd3;
    update_src();
    req = 4'b0001;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
    total++; if (txfifo_wr !== 1'b0) begin bad++; $display("FAIL single_wr_c1 got=%b exp=0", txfifo_wr); end
    step();
    total++; if (txfifo_wr !== 1'b1 || txfifo_data !== 8'hA5) begin
      bad++; $display("FAIL single_latency got=%b/%h exp=1/a5", txfifo_wr, txfifo_data);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_idle("single", 60);
    exp_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h03);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL single_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    clear_run();
    src_mem[1][0] = 8'h5A; src_len[1] = 1;
    src_mem[2][0] = 8'hC3; src_len[2] = 1;
    req_len = {8'd0, 8'd1, 8'd1, 8'd0};
    update_src();
    req = 4'b0110;
    wait_idle("rr", 80);
    exp_q = '{8'hA5, 8'h01, 8'h01, 8'h5A};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h5A);
`endif
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'hC3);
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'hC0);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rr_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
    total++; if (onehot_viol != 0) begin bad++; $display("FAIL rr_onehot got=%0d exp=0", onehot_viol); end
    total++; if (ready_viol != 0) begin bad++; $display("FAIL rr_ready_owner got=%0d exp=0", ready_viol); end
  endtask

  // Pointer now sits at 3, so ch3 must beat ch0; both are header-only packets.
  task automatic test_len_zero();
    clear_run();
    req_len = {8'd0, 8'd0, 8'd0, 8'd0};
    req = 4'b1001;
    wait_idle("len0", 80);
    exp_q = '{8'hA5, 8'h03, 8'h00};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h03);
`endif
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h00);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL len0_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL len0_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL len0_ready got=%0d exp=0", ready_seen); end
  endtask

  task automatic test_full_toggle();
    clear_run();
    src_mem[2][0] = 8'h01; src_mem[2][1] = 8'h02; src_mem[2][2] = 8'h03; src_mem[2][3] = 8'h04;
    src_len[2] = 4;
    req_len = {8'd0, 8'd4, 8'd0, 8'd0};
    full_mode = 1'b1;
    update_src();
    req = 4'b0100;
    wait_idle("full", 120);
    full_mode = 1'b0;
    txfifo_full = 1'b0;
    exp_q = '{8'hA5, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h02);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL full_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
    total++; if (hold_viol != 0) begin bad++; $display("FAIL full_hold got=%0d exp=0", hold_viol); end
    total++; if (stall_cnt == 0) begin bad++; $display("FAIL full_stalls got=0 exp=>0"); end
  endtask

  task automatic test_src_gaps();
    clear_run();
    src_mem[1][0] = 8'h10; src_mem[1][1] = 8'h20; src_mem[1][2] = 8'h30;
    src_mem[1][3] = 8'h40; src_mem[1][4] = 8'h50;
    src_len[1] = 5;
    req_len = {8'd0, 8'd0, 8'd5, 8'd0};
    gap_mode = 1'b1;
    update_src();
    req = 4'b0010;
    wait_idle("gaps", 120);
    gap_mode = 1'b0;
    exp_q = '{8'hA5, 8'h01, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h14);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL gaps_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL gaps_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
    total++; if (src_ptr[1] != 5) begin bad++; $display("FAIL gaps_consumed got=%0d exp=5", src_ptr[1]); end
    total++; if (bubble_cnt < 2) begin bad++; $display("FAIL gaps_bubbles got=%0d exp=>1", bubble_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_run();
    for (int i = 0; i < 6; i++) src_mem[2][i] = 8'h61 + 8'(i);
    src_len[2] = 6;
    req_len = {8'd0, 8'd6, 8'd0, 8'd0};
    update_src();
    req = 4'b0100;
    n = 0;
    while (out_q.size() < 5 && n < 50) begin step(); n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL rstmid_timeout got=%0d bytes exp=5", out_q.size()); end
    sys_rst = 1'b1;
    #1;
    total++; if (txfifo_wr !== 1'b0) begin bad++; $display("FAIL rstmid_wr got=%b exp=0", txfifo_wr); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rstmid_grant got=%b exp=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_ready got=%b exp=0000", src_ready); end
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear_run();
    src_mem[0][0] = 8'h77; src_len[0] = 1;
    src_mem[2][0] = 8'h88; src_len[2] = 1;
    req_len = {8'd0, 8'd1, 8'd0, 8'd1};
    update_src();
    req = 4'b0101;
    wait_idle("rstmid", 80);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h77};
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h76);
`endif
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h88);
`ifdef FT_TX_ARB_CSUM_EN
    exp_q.push_back(8'h8B);
`endif
    total++;
    if (out_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rstmid_len got=%0d exp=%0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    sys_rst     = 1'b1;
    req         = '0;
    req_len     = '0;
    src_data    = '0;
    src_valid   = '0;
    txfifo_full = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      src_len[c] = 0;
      src_ptr[c] = 0;
      for (int i = 0; i < 8; i++) src_mem[c][i] = 8'h00;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_full_toggle();
    test_src_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
